// File: rtl/flow_dispatcher_pkg.sv
// Shared definitions for the flow dispatcher: segment widths, FSM state codes
// and a small index helper for the round-robin search.
package flow_dispatcher_pkg;

  localparam int LEN_SEGMENT = 8;
  localparam int FLOW_W      = 4 * LEN_SEGMENT;

  typedef enum logic [1:0] {
    FD_IDLE = 2'd0,
    FD_ARM  = 2'd1,
    FD_FIRE = 2'd2,
    FD_WAIT = 2'd3
  } fd_state_t;

  // (base + offset) mod n, valid while base < n and offset < n
  function automatic int wrap_idx(input int base, input int offset, input int n);
    int j;
    j = base + offset;
    if (j >= n) j = j - n;
    return j;
  endfunction

endpackage

// File: rtl/flow_fifo.sv
// Request queue holding packed {SA,SB,SC,IP} segment sets in arrival order.
// Depth must be a power of two so the pointers wrap on their own.
module flow_fifo
  import flow_dispatcher_pkg::*;
#(
  parameter int W     = FLOW_W,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read out
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/flow_dispatcher.sv
// Queues new-flow requests and hands each one to an idle slave core, chosen
// round-robin, with a registered clock enable and a one-cycle start strobe.
module flow_dispatcher
  import flow_dispatcher_pkg::*;
#(
  parameter int N_SLAVE = 4,
  parameter int SEG_W   = LEN_SEGMENT,
  parameter int Q_DEPTH = 4,
  parameter int ACK_TMO = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ,
  input  logic [SEG_W-1:0]   SA_R,
  input  logic [SEG_W-1:0]   SB_R,
  input  logic [SEG_W-1:0]   SC_R,
  input  logic [SEG_W-1:0]   IP_R,
  output logic               Q_FULL,
  output logic               Q_EMPTY,
  output logic [SEG_W-1:0]   SA_M,
  output logic [SEG_W-1:0]   SB_M,
  output logic [SEG_W-1:0]   SC_M,
  output logic [SEG_W-1:0]   IP_M,
  output logic [N_SLAVE-1:0] START_NEW_FLOW,
  output logic [N_SLAVE-1:0] EN,
  input  logic [N_SLAVE-1:0] INT,
  output logic               DISP_ERR
);

  localparam int SEL_W = $clog2(N_SLAVE);
  localparam int FW    = 4 * SEG_W;
  localparam int TMR_W = $clog2(ACK_TMO + 1);
  localparam logic [N_SLAVE-1:0] ONE = 1;

  fd_state_t          state;
  fd_state_t          state_next;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   scan_idx;
  logic               pick_found;
  logic               do_pick;
  logic               do_fire;
  logic               pop;
  logic               timeout;
  logic [N_SLAVE-1:0] cand;
  logic [N_SLAVE-1:0] en_r;
  logic [N_SLAVE-1:0] en_next;
  logic [N_SLAVE-1:0] start_r;
  logic [TMR_W-1:0]   timer;
  logic [FW-1:0]      q_head;
  logic [FW-1:0]      seg_r;
  logic               q_full;
  logic               q_empty;
  logic               disp_err_r;

  flow_fifo #(
    .W     (FW),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (REQ && !q_full),
    .pop   (pop),
    .din   ({SA_R, SB_R, SC_R, IP_R}),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign cand = INT & ~en_r;

  // Scan downward so the candidate closest to rr_ptr is the one left standing
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = N_SLAVE - 1; k >= 0; k--) begin
      scan_idx = SEL_W'(wrap_idx(int'(rr_ptr), k, N_SLAVE));
      if (cand[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= FD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_pick    = 1'b0;
    do_fire    = 1'b0;
    pop        = 1'b0;
    timeout    = 1'b0;
    case (state)
      FD_IDLE: begin
        if (!q_empty && pick_found) begin
          do_pick    = 1'b1;
          state_next = FD_ARM;
        end
      end
      FD_ARM: begin
        do_fire    = 1'b1;
        state_next = FD_FIRE;
      end
      FD_FIRE: begin
        pop        = 1'b1;
        state_next = FD_WAIT;
      end
      FD_WAIT: begin
        if (!INT[sel]) begin
          state_next = FD_IDLE;
        end else if (timer == TMR_W'(ACK_TMO - 1)) begin
          timeout    = 1'b1;
          state_next = FD_IDLE;
        end
      end
      default: state_next = FD_IDLE;
    endcase

    // A slave that is enabled yet reports idle has finished its flow
    for (int i = 0; i < N_SLAVE; i++) begin
      en_next[i] = en_r[i];
      if (en_r[i] && INT[i] && (state == FD_IDLE || SEL_W'(i) != sel)) en_next[i] = 1'b0;
      if (timeout && SEL_W'(i) == sel) en_next[i] = 1'b0;
      if (do_pick && SEL_W'(i) == pick_idx) en_next[i] = 1'b1;
    end
  end

  // Strobe and segment bus load on the ARM->FIRE edge so both are valid in FIRE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sel        <= '0;
      rr_ptr     <= '0;
      en_r       <= '0;
      start_r    <= '0;
      seg_r      <= '0;
      timer      <= '0;
      disp_err_r <= 1'b0;
    end else begin
      en_r    <= en_next;
      start_r <= do_fire ? (ONE << sel) : '0;
      if (do_fire) seg_r <= q_head;
      if (do_pick) begin
        sel    <= pick_idx;
        rr_ptr <= (int'(pick_idx) == N_SLAVE - 1) ? '0 : pick_idx + 1'b1;
      end
      if (state == FD_FIRE)      timer <= '0;
      else if (state == FD_WAIT) timer <= timer + 1'b1;
      if (timeout) disp_err_r <= 1'b1;
    end
  end

  assign Q_FULL                   = q_full;
  assign Q_EMPTY                  = q_empty;
  assign {SA_M, SB_M, SC_M, IP_M} = seg_r;
  assign START_NEW_FLOW           = start_r;
  assign EN                       = en_r;
  assign DISP_ERR                 = disp_err_r;

endmodule

// File: tb/tb_flow_dispatcher.sv
// Bench for flow_dispatcher: a scoreboard of queued payloads checked against
// each start strobe, plus timed sequences for enable, timeout and reset.
module tb_flow_dispatcher;

  localparam int N   = 4;
  localparam int TMO = 15;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ   = 1'b0;
  logic [7:0] SA_R  = '0;
  logic [7:0] SB_R  = '0;
  logic [7:0] SC_R  = '0;
  logic [7:0] IP_R  = '0;
  logic [N-1:0] int_r = '1;
  logic       Q_FULL;
  logic       Q_EMPTY;
  logic [7:0] SA_M;
  logic [7:0] SB_M;
  logic [7:0] SC_M;
  logic [7:0] IP_M;
  logic [N-1:0] START_NEW_FLOW;
  logic [N-1:0] EN;
  logic       DISP_ERR;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] sc;
    logic [7:0] ip;
    bit         accept;
    int         slave;
  } vec_t;

  typedef struct {
    logic [N-1:0] start;
    logic [31:0]  payload;
  } mon_t;

  logic [31:0] exp_q[$];
  mon_t        mon_q[$];
  vec_t        vecs[8];

  flow_dispatcher #(
    .N_SLAVE (N),
    .SEG_W   (8),
    .Q_DEPTH (4),
    .ACK_TMO (TMO)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .REQ            (REQ),
    .SA_R           (SA_R),
    .SB_R           (SB_R),
    .SC_R           (SC_R),
    .IP_R           (IP_R),
    .Q_FULL         (Q_FULL),
    .Q_EMPTY        (Q_EMPTY),
    .SA_M           (SA_M),
    .SB_M           (SB_M),
    .SC_M           (SC_M),
    .IP_M           (IP_M),
    .START_NEW_FLOW (START_NEW_FLOW),
    .EN             (EN),
    .INT            (int_r),
    .DISP_ERR       (DISP_ERR)
  );

  always #5 CLK = ~CLK;

  // Capture every strobe together with the segment bus it was issued with
  always @(posedge CLK) begin
    #1;
    if (START_NEW_FLOW != '0) mon_q.push_back('{START_NEW_FLOW, {SA_M, SB_M, SC_M, IP_M}});
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Starts and ends on a falling edge; drives REQ for exactly one cycle
  task automatic applyStimulus(input vec_t v);
    checkOutput("q_full_before_req", {31'b0, Q_FULL}, {31'b0, !v.accept});
    REQ  = 1'b1;
    SA_R = v.sa;
    SB_R = v.sb;
    SC_R = v.sc;
    IP_R = v.ip;
    if (v.accept) exp_q.push_back({v.sa, v.sb, v.sc, v.ip});
    @(negedge CLK);
    REQ = 1'b0;
  endtask

  task automatic waitStart(input int slave, input bit ack);
    mon_t rec;
    int   cnt;
    cnt = 0;
    while (mon_q.size() == 0 && cnt < 40) begin
      @(negedge CLK);
      cnt++;
    end
    if (mon_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL start_timeout: got no strobe expected strobe for slave %0d", slave);
      return;
    end
    rec = mon_q.pop_front();
    checkOutput("start_slave", {28'b0, rec.start}, 32'(1) << slave);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL payload_extra: got %0h expected no dispatch", rec.payload);
    end else begin
      checkOutput("payload", rec.payload, exp_q.pop_front());
    end
    if (ack) int_r[slave] = 1'b0;
  endtask

  initial begin
    vec_t t;
    int   cnt;

    vecs[0] = '{8'h11, 8'h12, 8'h13, 8'h14, 1'b1, 1};
    vecs[1] = '{8'h21, 8'h22, 8'h23, 8'h24, 1'b1, 2};
    vecs[2] = '{8'h31, 8'h32, 8'h33, 8'h34, 1'b1, 3};
    vecs[3] = '{8'h41, 8'h42, 8'h43, 8'h44, 1'b1, 0};
    vecs[4] = '{8'h51, 8'h52, 8'h53, 8'h54, 1'b1, 1};
    vecs[5] = '{8'h61, 8'h62, 8'h63, 8'h64, 1'b1, 2};
    vecs[6] = '{8'h71, 8'h72, 8'h73, 8'h74, 1'b1, 3};
    vecs[7] = '{8'h81, 8'h82, 8'h83, 8'h84, 1'b0, 0};

    repeat (2) @(negedge CLK);
    checkOutput("rst_q_empty", {31'b0, Q_EMPTY}, 1);
    checkOutput("rst_q_full", {31'b0, Q_FULL}, 0);
    checkOutput("rst_en", {28'b0, EN}, 0);
    checkOutput("rst_start", {28'b0, START_NEW_FLOW}, 0);
    checkOutput("rst_seg", {SA_M, SB_M, SC_M, IP_M}, 0);
    checkOutput("rst_err", {31'b0, DISP_ERR}, 0);
    RESET = 1'b1;
    @(negedge CLK);

    // Single request into an empty queue with every slave idle
    t = '{8'h01, 8'h02, 8'h03, 8'h10, 1'b1, 0};
    applyStimulus(t);
    checkOutput("t1_en_before", {28'b0, EN}, 0);
    checkOutput("t1_q_empty", {31'b0, Q_EMPTY}, 0);
    @(negedge CLK);
    checkOutput("t1_en_rise", {28'b0, EN}, 4'b0001);
    checkOutput("t1_no_start_yet", {28'b0, START_NEW_FLOW}, 0);
    @(negedge CLK);
    checkOutput("t1_start", {28'b0, START_NEW_FLOW}, 4'b0001);
    checkOutput("t1_sa_m", {24'b0, SA_M}, 32'h01);
    checkOutput("t1_ip_m", {24'b0, IP_M}, 32'h10);
    waitStart(0, 1'b1);
    repeat (3) @(negedge CLK);
    checkOutput("t1_start_one_cycle", {28'b0, START_NEW_FLOW}, 0);
    checkOutput("t1_en_busy", {28'b0, EN}, 4'b0001);
    checkOutput("t1_q_drained", {31'b0, Q_EMPTY}, 1);

    // Slave 0 busy: three flows go to 1,2,3, then the queue fills and one is dropped
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
    for (int i = 0; i < 3; i++) waitStart(vecs[i].slave, 1'b1);
    repeat (5) @(negedge CLK);
    checkOutput("t2_no_candidate", mon_q.size(), 0);
    checkOutput("t2_held", {31'b0, Q_EMPTY}, 0);
    for (int i = 4; i < 8; i++) applyStimulus(vecs[i]);
    checkOutput("t2_full", {31'b0, Q_FULL}, 1);
    int_r[0] = 1'b1;
    waitStart(vecs[3].slave, 1'b1);
    int_r[3:1] = 3'b111;
    for (int i = 4; i < 7; i++) waitStart(vecs[i].slave, 1'b1);
    repeat (5) @(negedge CLK);
    checkOutput("t2_dropped_never_sent", mon_q.size(), 0);
    checkOutput("t2_scoreboard_empty", exp_q.size(), 0);
    checkOutput("t2_q_empty", {31'b0, Q_EMPTY}, 1);
    checkOutput("t2_en_all", {28'b0, EN}, 4'b1111);

    // Slave 2 finishes: only its enable drops
    int_r[2] = 1'b1;
    @(negedge CLK);
    checkOutput("t4_en2_release", {28'b0, EN}, 4'b1011);

    // Slave 2 never acknowledges: timeout, error flag, then the next flow proceeds
    t = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1, 2};
    applyStimulus(t);
    cnt = 0;
    while (START_NEW_FLOW == '0 && cnt < 40) begin
      @(negedge CLK);
      cnt++;
    end
    if (START_NEW_FLOW == '0) begin
      total++;
      bad++;
      $display("[TB] FAIL t3_start: got no strobe expected strobe for slave 2");
    end
    waitStart(2, 1'b0);
    t = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 1'b1, 2};
    applyStimulus(t);
    repeat (TMO - 2) @(negedge CLK);
    checkOutput("t3_err_not_yet", {31'b0, DISP_ERR}, 0);
    checkOutput("t3_en_held", {28'b0, EN}, 4'b1111);
    repeat (2) @(negedge CLK);
    checkOutput("t3_err_set", {31'b0, DISP_ERR}, 1);
    checkOutput("t3_en_dropped", {28'b0, EN}, 4'b1011);
    waitStart(2, 1'b1);
    checkOutput("t3_err_sticky", {31'b0, DISP_ERR}, 1);

    // Reset while waiting with two requests still queued
    int_r[1] = 1'b1;
    t = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b1, 1};
    applyStimulus(t);
    t = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b1, 0};
    applyStimulus(t);
    t = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 1'b1, 0};
    applyStimulus(t);
    waitStart(1, 1'b0);
    @(negedge CLK);
    checkOutput("t5_queued", {31'b0, Q_EMPTY}, 0);
    RESET = 1'b0;
    #1;
    checkOutput("t5_en", {28'b0, EN}, 0);
    checkOutput("t5_start", {28'b0, START_NEW_FLOW}, 0);
    checkOutput("t5_seg", {SA_M, SB_M, SC_M, IP_M}, 0);
    checkOutput("t5_err", {31'b0, DISP_ERR}, 0);
    checkOutput("t5_q_empty", {31'b0, Q_EMPTY}, 1);
    checkOutput("t5_q_full", {31'b0, Q_FULL}, 0);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b1;
    int_r = '1;
    @(negedge CLK);
    checkOutput("t5_no_stray_start", mon_q.size(), 0);
    t = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 1'b1, 0};
    applyStimulus(t);
    waitStart(0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
